// File: rtl/wash_phase_timer.sv
// wash_phase_timer: times each washing-machine phase.
// It watches the phase code from the controller, loads that phase's duration in
// seconds and counts it down through a clock prescaler. When the count expires it
// raises Trigger_clk_FSM for one cycle. Pause only takes effect in the spin phase.
//
// The DUT has no valid/ready handshake. The phase code is a level input. The DUT
// compares it with the registered copy every cycle, and any difference is a
// request to reload. Trigger_clk_FSM is a one-cycle, fire-and-forget pulse: the
// controller has to act on it in that cycle.
module wash_phase_timer #(
    parameter int CYCLES_PER_SEC = 4,
    parameter int T_FILL         = 120,
    parameter int T_WASH         = 300,
    parameter int T_RINSE        = 120,
    parameter int T_SPIN         = 60
) (
    input  logic       CLK,
    input  logic       Rst,
    input  logic [2:0] Duration_clk_FSM,
    input  logic       Pause_clk,
    output logic       Trigger_clk_FSM,
    output logic [8:0] Time_left,
    output logic       Timer_busy,
    output logic       Timer_paused,
    output logic [1:0] state_dbg_o
);

    localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_SEC - 1);
    localparam logic [2:0] CODE_SPIN = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      code_q, code_d;
    logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [8:0]      sec_cnt_q, sec_cnt_d;
    logic            trig_q, trig_d;

    logic [8:0]      dur_lookup;
    logic            code_timed;
    logic            code_change;
    logic            sec_tick;
    logic            pause_eff;

    assign code_change = (Duration_clk_FSM != code_q);
    assign sec_tick    = (pre_cnt_q == PRE_LAST);
    // Pause is judged against the registered code. A code change takes priority anyway.
    assign pause_eff   = Pause_clk && (code_q == CODE_SPIN);

    // Duration lookup for the incoming code. Codes without a duration go back to idle.
    always_comb begin
        dur_lookup = 9'd0;
        code_timed = 1'b0;
        case (Duration_clk_FSM)
            3'b001:  begin dur_lookup = 9'(T_FILL);  code_timed = 1'b1; end
            3'b010:  begin dur_lookup = 9'(T_WASH);  code_timed = 1'b1; end
            3'b011:  begin dur_lookup = 9'(T_RINSE); code_timed = 1'b1; end
            3'b100:  begin dur_lookup = 9'(T_SPIN);  code_timed = 1'b1; end
            default: begin dur_lookup = 9'd0;        code_timed = 1'b0; end
        endcase
    end

    // Next state and counters. A code change beats expiry and pause, which drops the running count.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pre_cnt_d = pre_cnt_q;
        sec_cnt_d = sec_cnt_q;
        trig_d    = 1'b0;
        if (code_change) begin
            code_d    = Duration_clk_FSM;
            pre_cnt_d = '0;
            if (code_timed) begin
                sec_cnt_d = dur_lookup;
                state_d   = S_RUN;
            end else begin
                sec_cnt_d = 9'd0;
                state_d   = S_IDLE;
            end
        end else begin
            case (state_q)
                S_RUN, S_PAUSE: begin
                    if (pause_eff) begin
                        // Both counters hold. The prescaler phase survives the pause.
                        state_d = S_PAUSE;
                    end else begin
                        // The resume edge also counts, so a pause of P cycles costs exactly P cycles.
                        state_d = S_RUN;
                        if (sec_tick) begin
                            pre_cnt_d = '0;
                            sec_cnt_d = sec_cnt_q - 9'd1;
                            if (sec_cnt_q == 9'd1) begin
                                trig_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end else begin
                            pre_cnt_d = pre_cnt_q + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    pre_cnt_d = '0;
                    sec_cnt_d = 9'd0;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and counter registers. Reset clears everything.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            code_q    <= 3'b000;
            pre_cnt_q <= '0;
            sec_cnt_q <= 9'd0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pre_cnt_q <= pre_cnt_d;
            sec_cnt_q <= sec_cnt_d;
            trig_q    <= trig_d;
        end
    end

    assign Trigger_clk_FSM = trig_q;
    assign Time_left       = sec_cnt_q;
    assign Timer_busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign Timer_paused    = (state_q == S_PAUSE);
    assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Testbench for wash_phase_timer. A tick-counting reference model predicts the outputs.
module tb_wash_phase_timer;

    localparam int CPS  = 4;
    localparam int TF   = 3;
    localparam int TW   = 5;
    localparam int TR   = 2;
    localparam int TS   = 2;
    localparam int W    = 9;

    logic       clk;
    logic       rst;
    logic [2:0] code;
    logic       pause;
    logic       trig;
    logic [8:0] time_left;
    logic       busy;
    logic       paused;
    logic [1:0] state_dbg;

    int tests_run = 0;
    int failed    = 0;

    logic [W-1:0] exp_q[$];

    wash_phase_timer #(
        .CYCLES_PER_SEC(CPS),
        .T_FILL(TF),
        .T_WASH(TW),
        .T_RINSE(TR),
        .T_SPIN(TS)
    ) dut (
        .CLK(clk),
        .Rst(rst),
        .Duration_clk_FSM(code),
        .Pause_clk(pause),
        .Trigger_clk_FSM(trig),
        .Time_left(time_left),
        .Timer_busy(busy),
        .Timer_paused(paused),
        .state_dbg_o(state_dbg)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model. It tracks how many counting cycles have elapsed in the current phase.
    logic [2:0] m_code;
    logic       m_busy, m_paused, m_trig;
    int         m_dur, m_ticks;

    function automatic int dur_of(input logic [2:0] c);
        case (c)
            3'b001:  return TF;
            3'b010:  return TW;
            3'b011:  return TR;
            3'b100:  return TS;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        m_trig = 1'b0;
        if (rst) begin
            m_code = 3'b000; m_busy = 1'b0; m_paused = 1'b0; m_dur = 0; m_ticks = 0;
        end else if (code != m_code) begin
            m_code = code; m_dur = dur_of(code); m_ticks = 0;
            m_busy = (m_dur != 0); m_paused = 1'b0;
        end else if (m_busy) begin
            if (pause && m_code == 3'b100) begin
                m_paused = 1'b1;
            end else begin
                m_paused = 1'b0;
                m_ticks++;
                if (m_ticks == m_dur * CPS) begin
                    m_trig = 1'b1; m_busy = 1'b0; m_paused = 1'b0;
                end
            end
        end
    end

    function automatic logic [11:0] exp_vec();
        logic [8:0] left;
        left = m_busy ? 9'(m_dur - m_ticks / CPS) : 9'd0;
        return {m_trig, left, m_busy, m_paused};
    endfunction

    wire [11:0] obs_vec = {trig, time_left, busy, paused};

    task automatic go_idle();
        code = 3'b000; pause = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int trigs = 0;
        rst = 1'b1; code = 3'b000; pause = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (obs_vec !== 12'd0) begin
            failed++; $display("FAIL reset_outputs got %h exp %h", obs_vec, 12'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                failed++; $display("FAIL idle_model cyc=%0d got %h exp %h", i, obs_vec, exp_vec());
            end
            if (trig === 1'b1 || busy !== 1'b0 || time_left !== 9'd0) trigs++;
        end
        tests_run++;
        if (trigs !== 0) begin
            failed++; $display("FAIL idle_quiet got %0d active cycles exp 0", trigs);
        end
    endtask

    task automatic test_fill();
        int pulses = 0;
        int trig_at = -1;
        go_idle();
        code = 3'b001;
        for (int i = 0; i <= 52; i++) begin
            @(negedge clk);
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                failed++; $display("FAIL fill_model cyc=%0d got %h exp %h", i, obs_vec, exp_vec());
            end
            if (i % 4 == 0 && i <= 12) begin
                tests_run++;
                if (time_left !== 9'(3 - i / 4)) begin
                    failed++; $display("FAIL fill_time_left cyc=%0d got %0d exp %0d", i, time_left, 3 - i / 4);
                end
            end
            if (trig === 1'b1) begin pulses++; trig_at = i; end
        end
        tests_run++;
        if (pulses !== 1 || trig_at !== 12) begin
            failed++; $display("FAIL fill_trigger got %0d pulses at %0d exp 1 at 12", pulses, trig_at);
        end
    endtask

    task automatic test_pause();
        for (int r = 0; r < 2; r++) begin
            int pcount = 0;
            int trig_at = -1;
            int exp_at = (r == 0) ? 14 : 20;
            int exp_p  = (r == 0) ? 6 : 0;
            go_idle();
            for (int i = 0; i < 30; i++) begin
                if (i == 0) code = (r == 0) ? 3'b100 : 3'b010;
                pause = (i >= 3 && i <= 8);
                @(negedge clk);
                tests_run++;
                if (obs_vec !== exp_vec()) begin
                    failed++; $display("FAIL pause_model r=%0d cyc=%0d got %h exp %h", r, i, obs_vec, exp_vec());
                end
                if (paused === 1'b1) pcount++;
                if (trig === 1'b1 && trig_at < 0) trig_at = i;
            end
            tests_run++;
            if (pcount !== exp_p || trig_at !== exp_at) begin
                failed++;
                $display("FAIL pause_timing r=%0d got paused=%0d trig=%0d exp paused=%0d trig=%0d",
                         r, pcount, trig_at, exp_p, exp_at);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [4];
        logic [W-1:0] exp_gap;
        seq = '{3'b011, 3'b010, 3'b011, 3'b001};
        exp_q.push_back(9'd8);
        exp_q.push_back(9'd20);
        exp_q.push_back(9'd8);
        exp_q.push_back(9'd12);
        go_idle();
        for (int p = 0; p < 4; p++) begin
            int c = 0;
            bit got = 0;
            if (p == 3) begin
                code = 3'b101;
                @(negedge clk);
                tests_run++;
                if (obs_vec !== exp_vec() || busy !== 1'b0) begin
                    failed++; $display("FAIL b2b_done_code got %h exp %h", obs_vec, exp_vec());
                end
            end
            code = seq[p];
            while (!got && c < 100) begin
                @(negedge clk);
                tests_run++;
                if (obs_vec !== exp_vec()) begin
                    failed++; $display("FAIL b2b_model p=%0d c=%0d got %h exp %h", p, c, obs_vec, exp_vec());
                end
                if (trig === 1'b1) got = 1; else c++;
            end
            exp_gap = exp_q.pop_front();
            tests_run++;
            if (!got || W'(c) !== exp_gap) begin
                failed++; $display("FAIL b2b_gap p=%0d got %0d (seen=%0d) exp %0d", p, c, got, exp_gap);
            end
        end
    endtask

    task automatic test_reload_on_expiry();
        int pulses = 0;
        go_idle();
        code = 3'b001;
        for (int i = 0; i < 12; i++) @(negedge clk);
        code = 3'b010;
        @(negedge clk);
        tests_run++;
        if (trig !== 1'b0 || time_left !== 9'd5 || busy !== 1'b1) begin
            failed++; $display("FAIL reload_expiry got trig=%b left=%0d busy=%b exp trig=0 left=5 busy=1",
                               trig, time_left, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (trig === 1'b1) pulses++;
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                failed++; $display("FAIL reload_model cyc=%0d got %h exp %h", i, obs_vec, exp_vec());
            end
        end
        tests_run++;
        if (pulses !== 0) begin
            failed++; $display("FAIL reload_no_trig got %0d exp 0", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        go_idle();
        code = 3'b100;
        repeat (3) @(negedge clk);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; code = 3'b000; pause = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (obs_vec !== 12'd0) begin
            failed++; $display("FAIL reset_mid_run got %h exp %h", obs_vec, 12'd0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trig === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            failed++; $display("FAIL reset_no_trig got %0d exp 0", pulses);
        end
    endtask

    task automatic test_untimed();
        logic [2:0] ucodes [3];
        ucodes = '{3'b110, 3'b111, 3'b101};
        for (int u = 0; u < 3; u++) begin
            int pulses = 0;
            go_idle();
            code = 3'b001;
            repeat (3) @(negedge clk);
            code = ucodes[u];
            @(negedge clk);
            tests_run++;
            if (time_left !== 9'd0 || busy !== 1'b0 || trig !== 1'b0) begin
                failed++; $display("FAIL untimed code=%b got left=%0d busy=%b trig=%b exp 0 0 0",
                                   ucodes[u], time_left, busy, trig);
            end
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (trig === 1'b1 || busy === 1'b1) pulses++;
            end
            tests_run++;
            if (pulses !== 0) begin
                failed++; $display("FAIL untimed_quiet code=%b got %0d exp 0", ucodes[u], pulses);
            end
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 29) == 0)
                code = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            @(negedge clk);
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                failed++; $display("FAIL random_model n=%0d got %h exp %h", n, obs_vec, exp_vec());
            end
        end
        rst = 1'b0; pause = 1'b0;
    endtask

    initial begin
        rst = 1'b1; code = 3'b000; pause = 1'b0;
        test_reset();
        test_fill();
        test_pause();
        test_back_to_back();
        test_reload_on_expiry();
        test_reset_mid_run();
        test_untimed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Phase-duration timer for the washing-machine controller. It watches the 3-bit phase code driven by the controller FSM and loads the matching phase duration in seconds. It counts that duration down with a clock prescaler and issues a one-cycle `Trigger_clk_FSM` pulse on expiry, which advances the FSM. Pause is honoured only during the spin phase. Remaining time is exported for the front-panel display.

## Interface
Parameters:
- `CYCLES_PER_SEC`, 4: clock cycles per timer second. Synthesis builds override it with the board frequency. Minimum 1.
- `T_FILL`, 120: seconds for phase code 3'b001 (fill).
- `T_WASH`, 300: seconds for phase code 3'b010 (wash).
- `T_RINSE`, 120: seconds for phase code 3'b011 (rinse).
- `T_SPIN`, 60: seconds for phase code 3'b100 (spin).
- All `T_*` values are in the range 1..511.

Ports:
- `CLK` input 1: system clock. All logic on the rising edge.
- `Rst` input 1: reset, synchronous, active-high.
- `Duration_clk_FSM` input 3: phase code from the controller.
- `Pause_clk` input 1: pause request. Effective only while the code is 3'b100.
- `Trigger_clk_FSM` output 1: one-cycle expiry pulse, registered.
- `Time_left` output 9: seconds remaining in the current phase, registered.
- `Timer_busy` output 1: high while counting or paused.
- `Timer_paused` output 1: high while the count is frozen by `Pause_clk`.

## Operation
- Registers:
  - `Code_q` (3b): last sampled phase code.
  - `Pre_cnt` (ceil(log2(CYCLES_PER_SEC)) bits, at least 1): prescaler.
  - `Sec_cnt` (9b): seconds remaining.
  - FSM state.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Duration lookup:
  - 001 → `T_FILL`; 010 → `T_WASH`; 011 → `T_RINSE`; 100 → `T_SPIN`.
  - 000 (idle), 101 (done) and 110/111 (invalid) are untimed.
- Code change, checked every cycle as `Duration_clk_FSM != Code_q`. Highest priority after reset:
  - `Code_q` takes the new code.
  - For a timed code: `Sec_cnt` ← duration, `Pre_cnt` ← 0, state → RUN.
  - For an untimed code: `Sec_cnt` ← 0, state → IDLE.
  - This also applies in RUN, PAUSE and DONE. A running count is abandoned with no trigger.
- RUN, no pause in effect:
  - `Pre_cnt` increments.
  - When `Pre_cnt == CYCLES_PER_SEC-1`: `Pre_cnt` ← 0 and `Sec_cnt` decrements.
  - If that decrement takes `Sec_cnt` from 1 to 0: assert `Trigger_clk_FSM` and go to DONE.
- RUN → PAUSE when `Pause_clk == 1` and `Code_q == 3'b100`.
  - `Pre_cnt` and `Sec_cnt` freeze.
- PAUSE → RUN when `Pause_clk == 0`. Counting resumes from the frozen `Pre_cnt` with no lost or extra cycles.
- `Pause_clk` is ignored in every other phase.
- DONE: no further triggers until the code changes. Pause is ignored.
- IDLE: counters hold at 0. No triggers.
- Outputs:
  - `Time_left = Sec_cnt`.
  - `Timer_busy` = state is RUN or PAUSE.
  - `Timer_paused` = state is PAUSE.
  - `Trigger_clk_FSM` is high for exactly one cycle per expiry.
- Double-wash loop (011→010→011) and restart (101→001): each code change reloads a full duration.

## Timing
- Reset: when `Rst` is high at a rising edge:
  - State → IDLE, `Code_q` → 3'b000, `Pre_cnt` → 0, `Sec_cnt` → 0.
  - `Trigger_clk_FSM`, `Time_left`, `Timer_busy`, `Timer_paused` all → 0.
  - Reset overrides every other condition, including mid-count and mid-pause.
- Code change applied at edge k (timed code, duration D, no pause):
  - `Timer_busy` and `Time_left = D` are visible after edge k.
  - `Sec_cnt` decrements at edges k + n·`CYCLES_PER_SEC`, for n = 1..D.
  - `Trigger_clk_FSM` is high during the cycle after edge k + D·`CYCLES_PER_SEC` and low after the next edge.
  - `Timer_busy` drops at the same edge `Trigger_clk_FSM` rises.
- Pause held for P cycles delays the trigger by exactly P cycles. PAUSE is entered and left on the edge that samples the `Pause_clk` change.
- Simultaneous events:
  - Code change on the same edge that would expire the count: the reload wins and no trigger fires.
  - Pause on the expiry edge: the pause wins; the trigger fires after resume, once the remaining count completes.
- Latency from code change to first count activity: 1 cycle (registered compare).

## Test plan
Sim parameters: `CYCLES_PER_SEC`=4, `T_FILL`=3, `T_WASH`=5, `T_RINSE`=2, `T_SPIN`=2.
- Reset, then code 000 held for 50 cycles → outputs stay 0 and no trigger fires.
- Code 001 applied at edge k → `Time_left` reads 3, 2, 1, 0 at edges k, k+4, k+8, k+12. Exactly one `Trigger_clk_FSM` pulse after edge k+12. No further pulse over the next 40 cycles with the code held.
- Code 100 at edge k, `Pause_clk` high for 6 cycles starting at edge k+3 → `Timer_paused`=1 for 6 cycles, trigger after edge k+14. The same pause sequence with code 010 → pause ignored; trigger after edge k+20.
- Code sequence 011 → 010 → 011, each code applied in the cycle following its predecessor's trigger → each code change reloads a full duration: triggers follow 8 cycles after the 011 load, then 20, then 8. The same holds for 101 → 001 restart.
- Code changed from 001 to 010 on the expiry edge of 001 → no trigger for 001 and `Time_left`=5. `Rst` asserted mid-RUN for 1 cycle → all outputs 0 on the following cycle and no trigger.
- Codes 110/111 and 101 → IDLE, `Time_left`=0, `Timer_busy`=0, no trigger.
